alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/opcode interface.
- Registers one decoded instruction per handshake and drives A, B and ALU_operation into the EX-stage ALU.
- Sits between the ID stage (instruction, register-file reads, PC) and the ALU, acting as the ID/EX pipeline register with valid/ready flow control and flush.
- Operation codes are the shared `ALU_* macros from header.sv.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the held and any accepted instruction (branch mispredict / trap).
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  raw RV32I instruction.
- pc  in  32  instruction address.
- rs1_data  in  32  register-file read port 1.
- rs2_data  in  32  register-file read port 2.
- out_valid  out  1  A/B/ALU_operation hold a valid operation.
- out_ready  in  1  EX consumes this cycle.
- A  out  32  ALU operand A.
- B  out  32  ALU operand B.
- ALU_operation  out  4  `ALU_* code.
- rd  out  5  inst[11:7] passthrough.

Behaviour:
- Single-entry register stage.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready: decoded values load on the next clk edge and out_valid <= 1.
  - out_valid && out_ready && !accept: out_valid <= 0.
  - While out_valid && !out_ready, all outputs hold stable.
- Latency: one cycle from accept to out_valid. Full throughput is one operation per cycle when out_ready stays high.
- Priority: rst > flush > accept.
  - flush: out_valid <= 0 and any same-cycle accept is discarded. in_ready is not gated by flush.
  - rst: out_valid=0, A=0, B=0, rd=0, ALU_operation=`ALU_ADD. Reset mid-stall drops the held operation.
- Decode by opcode inst[6:0]. f3 = inst[14:12], f7 = inst[31:25].
  - OP 0110011, A=rs1, B=rs2.
    - f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - f7=0100000: f3 000 SUB, f3 101 SRA.
    - Any other f7/f3 combination is illegal.
  - OP-IMM 0010011, A=rs1.
    - B = sign-extended inst[31:20]; same f3 map as OP, with 000 as ADD.
    - f3 001: requires f7=0000000 (SLL).
    - f3 101: requires f7=0000000 (SRL) or 0100000 (SRA).
    - For both shift cases B = {27'b0, inst[24:20]}.
  - LUI 0110111: A=0, B={inst[31:12],12'b0}, ADD.
  - AUIPC 0010111: A=pc, B=U-imm, ADD.
  - LOAD 0000011: A=rs1, B=sign-extended I-imm, ADD.
  - STORE 0100011: A=rs1, B=sign-extended {inst[31:25],inst[11:7]}, ADD.
  - BRANCH 1100011, A=rs1, B=rs2: f3 000/001 SUB; 100/101 SLT; 110/111 SLTU; 010/011 illegal.
  - Any other opcode is illegal.
- Illegal decode: registered as A=0, B=0, ALU_operation=`ALU_ADD (harmless NOP); out_valid still asserts.
- No arithmetic is performed in this block. All extension is done to 32 bits; there is no width overflow.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_EN.
- Defined:
  - Adds output port illegal (1 bit), registered alongside the other outputs with the same hold/flush rules.
  - illegal = 1 for illegal decodes; A, B and op are still forced to the NOP values.
  - Reset value 0.
- Undefined: port absent; illegal decodes are silently issued as NOP.

Test Plan:
- Reset, then "add x3,x1,x2" (0x002081B3) with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, A=5, B=7, ALU_operation=`ALU_ADD, rd=3.
- "srai x1,x2,4" (0x40415093), rs1=0x80000000 → A=0x80000000, B=4, op=`ALU_SRA. "addi x1,x0,-1" → B=0xFFFFFFFF, op=`ALU_ADD.
- Back-to-back stream of 4 OP instructions with out_ready=1 → 4 consecutive out_valid cycles, in_ready held 1.
- Stall: issue LUI 0x12345 (A=0, B=0x12345000), then hold out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs stable; on out_ready=1 the next instruction loads one cycle later.
- Flush asserted in the same cycle as an accept of "bltu" → next cycle out_valid=0. With ALU_ISSUE_ILLEGAL_EN, opcode 0x0000007F → illegal=1, A=0, B=0, op=`ALU_ADD.
- rst asserted while out_valid=1 and out_ready=0 → next cycle all outputs at reset values, in_ready=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX register stage: decodes one RV32I instruction per handshake into ALU operands and opcode.
// Optional macro ALU_ISSUE_ILLEGAL_EN adds a registered 'illegal' output flag.

`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`define ALU_SLL  4'b0001
`define ALU_SLT  4'b0010
`define ALU_SLTU 4'b0011
`define ALU_XOR  4'b0100
`define ALU_SRL  4'b0101
`define ALU_OR   4'b0110
`define ALU_AND  4'b0111
`define ALU_SUB  4'b1000
`define ALU_SRA  4'b1101
`endif

module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALU_operation,
    output logic [4:0]      rd
`ifdef ALU_ISSUE_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [3:0]      f3_op;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u  = {inst[31:12], 12'b0};
    assign shamt  = {27'b0, inst[24:20]};

    // Base funct3 map shared by OP and OP-IMM (funct7 variants handled below).
    always_comb begin
        case (f3)
            3'b000:  f3_op = `ALU_ADD;
            3'b001:  f3_op = `ALU_SLL;
            3'b010:  f3_op = `ALU_SLT;
            3'b011:  f3_op = `ALU_SLTU;
            3'b100:  f3_op = `ALU_XOR;
            3'b101:  f3_op = `ALU_SRL;
            3'b110:  f3_op = `ALU_OR;
            default: f3_op = `ALU_AND;
        endcase
    end

    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;
    logic [3:0]      op_next;
    logic            illegal_next;

    always_comb begin
        a_next       = '0;
        b_next       = '0;
        op_next      = `ALU_ADD;
        illegal_next = 1'b0;
        case (opcode)
            OPC_OP: begin
                a_next = rs1_data;
                b_next = rs2_data;
                if (f7 == F7_ZERO)
                    op_next = f3_op;
                else if (f7 == F7_ALT && f3 == 3'b000)
                    op_next = `ALU_SUB;
                else if (f7 == F7_ALT && f3 == 3'b101)
                    op_next = `ALU_SRA;
                else
                    illegal_next = 1'b1;
            end
            OPC_IMM: begin
                a_next  = rs1_data;
                b_next  = imm_i;
                op_next = f3_op;
                if (f3 == 3'b001) begin
                    b_next       = shamt;
                    illegal_next = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    b_next = shamt;
                    if (f7 == F7_ALT)
                        op_next = `ALU_SRA;
                    else if (f7 != F7_ZERO)
                        illegal_next = 1'b1;
                end
            end
            OPC_LUI: begin
                b_next = imm_u;
            end
            OPC_AUIPC: begin
                a_next = pc;
                b_next = imm_u;
            end
            OPC_LOAD: begin
                a_next = rs1_data;
                b_next = imm_i;
            end
            OPC_STORE: begin
                a_next = rs1_data;
                b_next = imm_s;
            end
            OPC_BRANCH: begin
                a_next = rs1_data;
                b_next = rs2_data;
                case (f3)
                    3'b000, 3'b001: op_next = `ALU_SUB;
                    3'b100, 3'b101: op_next = `ALU_SLT;
                    3'b110, 3'b111: op_next = `ALU_SLTU;
                    default:        illegal_next = 1'b1;
                endcase
            end
            default: illegal_next = 1'b1;
        endcase
        // Illegal encodings are issued as a harmless ADD 0,0.
        if (illegal_next) begin
            a_next  = '0;
            b_next  = '0;
            op_next = `ALU_ADD;
        end
    end

    logic            valid_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [3:0]      op_reg;
    logic [4:0]      rd_reg;
    logic            illegal_reg;
    logic            accept;

    assign in_ready = !valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= `ALU_ADD;
            rd_reg      <= '0;
            illegal_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg   <= 1'b1;
            a_reg       <= a_next;
            b_reg       <= b_next;
            op_reg      <= op_next;
            rd_reg      <= inst[11:7];
            illegal_reg <= illegal_next;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid     = valid_reg;
    assign A             = a_reg;
    assign B             = b_reg;
    assign ALU_operation = op_reg;
    assign rd            = rd_reg;

`ifdef ALU_ISSUE_ILLEGAL_EN
    assign illegal = illegal_reg;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_reg;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a behavioural decode/handshake model.

`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`define ALU_SLL  4'b0001
`define ALU_SLT  4'b0010
`define ALU_SLTU 4'b0011
`define ALU_XOR  4'b0100
`define ALU_SRL  4'b0101
`define ALU_OR   4'b0110
`define ALU_AND  4'b0111
`define ALU_SUB  4'b1000
`define ALU_SRA  4'b1101
`endif

module tb_alu_issue_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inst, pc, rs1_data, rs2_data, A, B;
    logic [3:0]  ALU_operation;
    logic [4:0]  rd;
    logic        ill_obs;

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
    logic illegal;
    assign ill_obs = illegal;
`else
    localparam bit ILL_EN = 1'b0;
    assign ill_obs = 1'b0;
`endif

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALU_operation(ALU_operation), .rd(rd)
`ifdef ALU_ISSUE_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } dec_t;

    // Reference stage state
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_ill;
    logic        obs_ready, exp_ready;

    function automatic logic [3:0] alu_of_f3(input logic [2:0] f);
        logic [3:0] tbl [8];
        tbl = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
        return tbl[f];
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] r1, input logic [31:0] r2);
        dec_t d;
        logic [2:0]  f3 = i[14:12];
        logic [6:0]  f7 = i[31:25];
        logic [31:0] imm_i = 32'($signed(i[31:20]));
        logic [31:0] imm_s = 32'($signed({i[31:25], i[11:7]}));
        logic [31:0] imm_u = i & 32'hFFFF_F000;
        logic [31:0] sh    = 32'(i[24:20]);
        d = '{a: 32'd0, b: 32'd0, op: `ALU_ADD, ill: 1'b0};
        case (i[6:0])
            7'h33: begin
                d.a = r1; d.b = r2;
                if (f7 == 7'h00) d.op = alu_of_f3(f3);
                else if (f7 == 7'h20 && f3 == 3'd0) d.op = `ALU_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) d.op = `ALU_SRA;
                else d.ill = 1'b1;
            end
            7'h13: begin
                d.a = r1;
                if (f3 == 3'd1) begin
                    d.b = sh; d.op = `ALU_SLL; d.ill = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    d.b = sh;
                    if (f7 == 7'h00) d.op = `ALU_SRL;
                    else if (f7 == 7'h20) d.op = `ALU_SRA;
                    else d.ill = 1'b1;
                end else begin
                    d.b = imm_i; d.op = alu_of_f3(f3);
                end
            end
            7'h37: d.b = imm_u;
            7'h17: begin d.a = p;  d.b = imm_u; end
            7'h03: begin d.a = r1; d.b = imm_i; end
            7'h23: begin d.a = r1; d.b = imm_s; end
            7'h63: begin
                d.a = r1; d.b = r2;
                if (f3 == 3'd2 || f3 == 3'd3) d.ill = 1'b1;
                else if (f3 < 3'd4) d.op = `ALU_SUB;
                else if (f3 < 3'd6) d.op = `ALU_SLT;
                else d.op = `ALU_SLTU;
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) begin d.a = 0; d.b = 0; d.op = `ALU_ADD; end
        return d;
    endfunction

    function automatic logic [74:0] obs_vec();
        return {out_valid, A, B, ALU_operation, rd, ill_obs};
    endfunction

    function automatic logic [74:0] exp_vec();
        return {m_valid, m_a, m_b, m_op, m_rd, ILL_EN ? m_ill : 1'b0};
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0] opcs [9];
        logic [31:0] i;
        logic [6:0] f7;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h73, 7'h00};
        i = $urandom;
        i[6:0] = opcs[$urandom_range(0, 8)];
        if (i[6:0] == 7'h00) i[6:0] = 7'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        i[31:25] = f7;
        return i;
    endfunction

    // Advances one clock: records in_ready before the edge and updates the model at the edge.
    task automatic tick();
        dec_t d;
        #1;
        obs_ready = in_ready;
        exp_ready = !m_valid || out_ready;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_a = 0; m_b = 0; m_op = `ALU_ADD; m_rd = 0; m_ill = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (in_valid && exp_ready) begin
            d = ref_decode(inst, pc, rs1_data, rs2_data);
            m_valid = 1; m_a = d.a; m_b = d.b; m_op = d.op; m_rd = inst[11:7]; m_ill = d.ill;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [74:0] want;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        inst = 0; pc = 0; rs1_data = 0; rs2_data = 0;
        tick(); tick();
        rst = 0;
        want = {1'b0, 32'd0, 32'd0, `ALU_ADD, 5'd0, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), want);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [74:0] want;
        in_valid = 1; out_ready = 1; pc = 32'h100;
        inst = 32'h002081B3; rs1_data = 5; rs2_data = 7;
        tick();
        want = {1'b1, 32'd5, 32'd7, `ALU_ADD, 5'd3, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL add_x3: got %h expected %h", obs_vec(), want);
        end
        inst = 32'h40415093; rs1_data = 32'h8000_0000;
        tick();
        want = {1'b1, 32'h8000_0000, 32'd4, `ALU_SRA, 5'd1, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL srai: got %h expected %h", obs_vec(), want);
        end
        inst = 32'hFFF00093; rs1_data = 0;
        tick();
        want = {1'b1, 32'd0, 32'hFFFF_FFFF, `ALU_ADD, 5'd1, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL addi_neg1: got %h expected %h", obs_vec(), want);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        in_valid = 1; out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            inst = {7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'h33};
            rs1_data = $urandom; rs2_data = $urandom;
            tick();
            checks++;
            if (obs_ready !== 1'b1) begin
                failures++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, obs_ready);
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL b2b_out[%0d]: got %h expected %h", k, obs_vec(), exp_vec());
            end
            if (out_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 4) begin
            failures++; $display("FAIL b2b_valid_count: got %0d expected 4", nvalid);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_stall();
        logic [74:0] want;
        in_valid = 1; out_ready = 1;
        inst = 32'h123452B7; rs1_data = $urandom;
        tick();
        want = {1'b1, 32'd0, 32'h1234_5000, `ALU_ADD, 5'd5, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL stall_lui: got %h expected %h", obs_vec(), want);
        end
        out_ready = 0; inst = 32'h002081B3; rs1_data = 32'd11; rs2_data = 32'd22;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs_ready !== 1'b0) begin
                failures++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", k, obs_ready);
            end
            checks++;
            if (obs_vec() !== want) begin
                failures++; $display("FAIL stall_hold[%0d]: got %h expected %h", k, obs_vec(), want);
            end
        end
        out_ready = 1;
        tick();
        want = {1'b1, 32'd11, 32'd22, `ALU_ADD, 5'd3, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL stall_release: got %h expected %h", obs_vec(), want);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        in_valid = 1; out_ready = 1; flush = 1;
        inst = 32'h0020E063; rs1_data = 3; rs2_data = 4;
        tick();
        flush = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_accept: got out_valid=%b expected 0", out_valid);
        end
        // Flush also kills a held, stalled operation.
        in_valid = 1; tick();
        in_valid = 0; out_ready = 0; flush = 1; tick();
        flush = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_held: got out_valid=%b expected 0", out_valid);
        end
        out_ready = 1;
    endtask

    task automatic test_illegal();
        logic [74:0] want;
        in_valid = 1; out_ready = 1;
        inst = 32'h0000007F; rs1_data = $urandom | 1; rs2_data = $urandom | 1;
        tick();
        want = {1'b1, 32'd0, 32'd0, `ALU_ADD, 5'd0, ILL_EN};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL illegal_opcode: got %h expected %h", obs_vec(), want);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            inst = gen_inst(); pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
            tick();
            checks++;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", k, obs_ready, exp_ready);
            end
            checks++;
            if (m_valid ? (obs_vec() !== exp_vec()) : (out_valid !== 1'b0)) begin
                failures++;
                $display("FAIL rand_out[%0d] inst=%h: got %h expected %h", k, inst, obs_vec(), exp_vec());
            end
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [74:0] want;
        in_valid = 1; out_ready = 1; inst = 32'h002081B3; rs1_data = 9; rs2_data = 8;
        tick();
        out_ready = 0; in_valid = 1;
        tick();
        rst = 1;
        tick();
        rst = 0; in_valid = 0;
        want = {1'b0, 32'd0, 32'd0, `ALU_ADD, 5'd0, 1'b0};
        checks++;
        if (obs_vec() !== want) begin
            failures++; $display("FAIL reset_mid_stall: got %h expected %h", obs_vec(), want);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_mid_stall_ready: got %b expected 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
